// File: rtl/iso_inv_affine_pipe.sv
// Composite-field S-box back end: per-byte inverse isomorphism back to the
// AES polynomial basis, then an optional AES affine transform, as a
// two-stage valid/ready pipeline with fully registered outputs.
module iso_inv_affine_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          AFFINE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_mode
);

    // DATA_W is expected to be a multiple of 8; each byte is an independent lane.
    localparam int unsigned LANES = DATA_W / 8;

    // Columns of the inverse-isomorphism matrix, column 7 in the top byte.
    // The forward map sends x^k to beta^k with beta = 0x4B, giving forward
    // columns {01,4B,3D,35,52,E0,5E,BD}; these are the columns of its inverse.
    localparam logic [63:0] ISO_INV_COLS = 64'h84EE_4A1F_0C5C_E101;

    // Affine matrix columns: column i is rotl8(0x1F, i).
    localparam logic [63:0] AFFINE_COLS  = 64'h8FC7_E3F1_F87C_3E1F;
    localparam logic [7:0]  AFFINE_CONST = 8'h63;

    // 8x8 GF(2) matrix times vector, matrix given as eight packed columns.
    function automatic logic [7:0] mat_mul8(input logic [7:0] x, input logic [63:0] cols);
        return ({8{x[0]}} & cols[7:0])   ^ ({8{x[1]}} & cols[15:8])  ^
               ({8{x[2]}} & cols[23:16]) ^ ({8{x[3]}} & cols[31:24]) ^
               ({8{x[4]}} & cols[39:32]) ^ ({8{x[5]}} & cols[47:40]) ^
               ({8{x[6]}} & cols[55:48]) ^ ({8{x[7]}} & cols[63:56]);
    endfunction

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_mode;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_mode;

    logic              adv1;
    logic              adv2;
    logic [DATA_W-1:0] iso_word;
    logic [DATA_W-1:0] aff_word;

    // Per-lane datapath: iso_inv feeds stage 1, affine (or bypass) feeds stage 2.
    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign iso_word[8*g +: 8] = mat_mul8(in_data[8*g +: 8], ISO_INV_COLS);
            if (AFFINE_EN) begin : g_aff
                assign aff_word[8*g +: 8] = mat_mul8(s1_data[8*g +: 8], AFFINE_COLS) ^ AFFINE_CONST;
            end else begin : g_noaff
                assign aff_word[8*g +: 8] = s1_data[8*g +: 8];
            end
        end
    endgenerate

    // Handshake: a stage advances when it is empty or the stage after it advances.
    // in_ready is held high while reset is asserted; anything taken then is dropped.
    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 || !rst_n;

    // Stage 1: capture the inverse-isomorphism result of an accepted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= iso_word;
                s1_mode <= in_mode;
            end
        end
    end

    // Stage 2: select iso-only or affine result; holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mode  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_mode ? s1_data : aff_word;
                s2_mode <= s1_mode;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_mode  = s2_mode;

endmodule

// File: tb/tb_iso_inv_affine_pipe.sv
// Bench for iso_inv_affine_pipe: directed vector table, exhaustive round trip,
// backpressure, mid-stream reset and full-throughput sequences, all checked
// through an expected-word scoreboard. A second instance has the affine removed.
module tb_iso_inv_affine_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_ready;

    logic        in_ready,   out_valid,   out_mode;
    logic [31:0] out_data;
    logic        in_ready_n, out_valid_n, out_mode_n;
    logic [31:0] out_data_n;

    always #5 clk = ~clk;

    iso_inv_affine_pipe #(.DATA_W(32), .AFFINE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    iso_inv_affine_pipe #(.DATA_W(32), .AFFINE_EN(1'b0)) dut_noaff (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .out_mode(out_mode_n)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] d_iso;
        logic        m;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic [31:0] exp;
        logic        exp_m;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[8];
    logic [7:0]  iso_tab[256];
    logic [7:0]  iso_inv_tab[256];
    logic [7:0]  inv_tab[256];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          out_count = 0;
    logic        lat_check = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_mode;
    logic [31:0] drv_exp, drv_exp_iso;
    logic        drv_exp_m;
    logic [31:0] wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AES field multiply, poly x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p = 8'h00; x = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = x[7] ? (8'(x << 1) ^ 8'h1B) : 8'(x << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Forward isomorphism: x^k maps to beta^k, beta = 0x4B.
    function automatic logic [7:0] fwd_iso(input logic [7:0] a);
        logic [63:0] cols;
        logic [7:0]  r, aa;
        cols = 64'hBD5E_E052_353D_4B01;
        r = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (aa[0]) r = r ^ cols[7:0];
            cols = cols >> 8;
            aa   = aa >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'({x, x} >> (8 - n));
    endfunction

    // AES affine in rotation form: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] aff_m(input logic [7:0] x);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic m, input logic aff_en);
        logic [31:0] r;
        logic [7:0]  y;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            y = iso_inv_tab[8'(d >> (8 * i))];
            if (!m && aff_en) y = aff_m(y);
            r = r | (32'(y) << (8 * i));
        end
        return r;
    endfunction

    // One negedge of observation: handshake, stall stability, scoreboard.
    task automatic mon_step();
        exp_t e;
        logic exp_rdy;
        cyc++;
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            exp_rdy = !(q.size() == 2 && !out_ready);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("in_ready_noaff", 32'(in_ready_n), 32'(exp_rdy));
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_mode", 32'(out_mode), 32'(prev_mode));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none (cycle %0d)", out_data, cyc);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_mode", 32'(out_mode), 32'(e.m));
                    chk("noaff_valid", 32'(out_valid_n), 32'd1);
                    chk("noaff_data", out_data_n, e.d_iso);
                    chk("noaff_mode", 32'(out_mode_n), 32'(e.m));
                    if (lat_check) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    out_count++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_mode  = out_mode;
            if (in_valid && in_ready) begin
                e.d = drv_exp; e.d_iso = drv_exp_iso; e.m = drv_exp_m; e.cyc = cyc;
                q.push_back(e);
            end
        end
    endtask

    // Offer one word until accepted; called right after a posedge.
    task automatic send(input logic [31:0] d, input logic m, input logic [31:0] exp,
                        input logic [31:0] exp_iso);
        logic ok;
        drv_exp = exp; drv_exp_iso = exp_iso; drv_exp_m = m;
        in_valid = 1'b1; in_data = d; in_mode = m;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] d, input logic m);
        send(d, m, model(d, m, 1'b1), model(d, m, 1'b0));
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_mode = 1'b0; out_ready = 1'b0;

        for (int a = 0; a < 256; a++) begin
            iso_tab[a] = fwd_iso(8'(a));
            iso_inv_tab[iso_tab[a]] = 8'(a);
        end
        inv_tab[0] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv_tab[a] = 8'(c);

        vecs[0] = '{32'h00010280, 1'b0, 32'h637CD790, 1'b0};
        vecs[1] = '{32'hBD4B0100, 1'b1, 32'h80020100, 1'b1};
        vecs[2] = '{32'hBD4B0100, 1'b0, 32'hEC5D7C63, 1'b0};
        vecs[3] = '{32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[4] = '{32'h00000000, 1'b0, 32'h63636363, 1'b0};
        vecs[5] = '{32'h523DE035, 1'b1, 32'h10042008, 1'b1};
        vecs[6] = '{32'h523DE035, 1'b0, 32'h921F809B, 1'b0};
        vecs[7] = '{32'h01010101, 1'b1, 32'h01010101, 1'b1};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_mode", 32'(out_mode), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_check = 1'b1;

        // Directed vector table, single word first then back to back
        send(vecs[0].d, vecs[0].m, vecs[0].exp, model(vecs[0].d, vecs[0].m, 1'b0));
        drain();
        for (int i = 1; i < 8; i++)
            send(vecs[i].d, vecs[i].m, vecs[i].exp, model(vecs[i].d, vecs[i].m, 1'b0));
        drain();

        // Exhaustive round trip through lane 0
        for (int a = 0; a < 256; a++)
            send({24'h0, iso_tab[a]}, 1'b1, {24'h0, 8'(a)}, {24'h0, 8'(a)});
        for (int a = 0; a < 256; a++)
            send({24'h0, iso_tab[inv_tab[a]]}, 1'b0, {24'h636363, aff_m(inv_tab[a])},
                 {24'h0, inv_tab[a]});
        drain();

        // Backpressure: out_ready pattern 1,0,0,1 while streaming 8 words
        lat_check = 1'b0;
        out_count = 0;
        fork
            for (int i = 0; i < 8; i++) begin
                wd = $urandom;
                send_m(wd, 1'($urandom_range(1)));
            end
            for (int i = 0; i < 40; i++) begin
                out_ready = ((i % 4) == 0) || ((i % 4) == 3);
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(out_count), 32'd8);

        // Mid-stream reset with two words in flight
        send_m(32'h11223344, 1'b0);
        send_m(32'h55667788, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_during", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
        end

        // Full throughput: 16 back-to-back words, latency checked per word
        lat_check = 1'b1;
        out_count = 0;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            send_m(wd, 1'(i % 2));
        end
        drain();
        chk("tp_count", 32'(out_count), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iso_inv_affine_pipe.md
Name: iso_inv_affine_pipe

Overview:
- Back end of the composite-field S-box datapath.
- Takes 32-bit words whose four bytes are in the composite-field basis, typically the outputs of the GF((2^4)^2) inverter.
- Maps each byte back to the standard GF(2^8) polynomial basis through the inverse isomorphism.
- Optionally applies the AES affine transform to each byte.
- Two-stage pipeline with valid/ready handshakes on both sides, sitting between the inverter and the SubBytes/key-expansion consumers.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8; the block has DATA_W/8 byte lanes.
- AFFINE_EN, 1, when 0 the affine logic is removed and every word takes the iso-only path regardless of in_mode.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  composite-basis bytes; lane i is in_data[8i+7:8i].
- in_mode  input  1  0 = inverse isomorphism then affine (S-box output); 1 = inverse isomorphism only.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_W  standard-basis result bytes.
- out_mode  output  1  in_mode carried alongside its word.

Behaviour:
- **Inverse isomorphism (iso_inv).** Per byte: the 8x8 GF(2) matrix that is the exact inverse of the team's forward isomorphism, so iso_inv(iso(a)) = a for all 256 values of a.
  - Reference points: forward maps 0x01->0x01, 0x02->0x4B, 0x80->0xBD.
  - Hence iso_inv(0x01)=0x01, iso_inv(0x4B)=0x02, iso_inv(0xBD)=0x80, iso_inv(0x00)=0x00.
- **Affine transform.** b = M*x ^ 0x63, where column i of M is rotl8(0x1F, i).
  - Examples: affine(0x00)=0x63, affine(0x01)=0x7C, affine(0x02)=0x5D, affine(0x80)=0xEC.
- **Stage 1.** s1_data <= iso_inv applied per lane; s1_mode <= in_mode; s1_valid set on an accepted input.
- **Stage 2.** s2_data <= s1_mode ? s1_data : affine(s1_data), per lane; s2_mode <= s1_mode.
- **Outputs.** out_data, out_mode and out_valid are driven directly by the stage-2 registers; there is no combinational path from in_data to out_data.
- **Handshake.**
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1.
  - An input is accepted when in_valid & in_ready.
  - Stage 2 loads from stage 1 when adv2; s2_valid <= s1_valid when adv2.
  - Stage 1 loads when adv1; s1_valid <= in_valid when adv1.
  - A stage whose valid is 0 may hold stale data.
- **Latency and throughput.**
  - Latency is 2 cycles: a word accepted at edge N is presented on out_data after edge N+1, and transfers at edge N+2 if out_ready is high.
  - With out_ready held high the pipeline sustains 1 word per cycle.
- **Backpressure.**
  - While out_valid & !out_ready: out_data and out_mode stay stable, and stage 2 holds.
  - Stage 1 may still fill if it is empty; once both stages are full, in_ready = 0.
  - No word is dropped or duplicated.
- **Simultaneous events.** When out_ready rises while both stages are full, the same cycle shifts stage 1 to stage 2 and accepts a new input, since in_ready = 1 combinationally.
- **in_ready rule.** in_ready depends only on register state and out_ready, never on in_valid.
- **Reset** (rst_n low at a rising edge):
  - s1_valid, s2_valid, out_valid = 0; s1/s2 data = 0; out_data = 0; out_mode = 0.
  - in_ready = 1 during and after reset.
  - Words in flight mid-operation are discarded.
- **AFFINE_EN=0.** Stage 2 passes s1_data through unchanged; out_mode still mirrors in_mode.

Test Plan:
- Reset then single word in_data=0x00010280, in_mode=0, out_ready=1 → out_valid exactly 2 cycles after acceptance; out_data = 0x637C[affine(iso_inv(0x02))][affine(iso_inv(0x80))], all four lanes checked against a golden model.
- in_data=0xBD4B0100, in_mode=1 → out_data=0x80020100, out_mode=1; the same word with in_mode=0 → 0xEC5D7C63.
- Exhaustive round trip: for all a in 0..255, drive iso(a) in lane 0 with in_mode=1 → lane 0 output equals a; with in_mode=0 → equals AES SBox(a) whenever the driven byte is iso(inv(a)).
- Backpressure: stream 8 words back-to-back with out_ready toggling 1,0,0,1,... →
  - in_ready drops only while both stages are full;
  - out_data is stable while stalled;
  - output order and count match the input (8 words, no loss or duplication).
- Mid-stream reset: two words in flight, assert rst_n=0 for one cycle → out_valid=0 and out_data=0 the next cycle, in_ready=1, no stale word emitted afterward.
- Full throughput: 16 words with in_valid=1 and out_ready=1 continuously → 16 outputs on 16 consecutive cycles starting 2 cycles after the first acceptance.
